// File: rtl/cpu_pkg.sv
// cpu_pkg: shared core widths, reset values and opcode constants.
package cpu_pkg;
    localparam int XLEN = 32;
    localparam int REG_ADDR_W = 5;
    localparam logic [XLEN-1:0] PC_RESET_VAL = 32'h8000_0000;
    localparam logic [6:0] OP_LOAD = 7'b000_0011;
    localparam logic [6:0] OP_STORE = 7'b010_0011;
    localparam logic [6:0] OP_SYSTEM = 7'b111_0011;
endpackage

// File: rtl/gen_reg.sv
// gen_reg: enabled register with asynchronous active-low reset to a parameterized value.
module gen_reg #(
    parameter int WIDTH = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    assign q_d = en_i ? d_i : q_q;
    assign q_o = q_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_q <= RESET_VAL;
        else q_q <= q_d;
    end
endmodule

// File: rtl/key_mux.sv
// key_mux: combinational key lookup over a packed table, lowest matching entry wins.
module key_mux #(
    parameter int NR_KEY = 1,
    parameter int KEY_LEN = 7,
    parameter int DATA_LEN = 1
) (
    input  logic [KEY_LEN-1:0]                   key_i,
    input  logic [DATA_LEN-1:0]                  default_i,
    input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut_i,
    output logic [DATA_LEN-1:0]                  out_o
);
    localparam int ENT_W = KEY_LEN + DATA_LEN;

    // Scanning from the top down lets the lowest-index match overwrite the rest.
    always_comb begin
        out_o = default_i;
        for (int i = NR_KEY - 1; i >= 0; i--)
            if (lut_i[i*ENT_W+DATA_LEN +: KEY_LEN] == key_i) out_o = lut_i[i*ENT_W +: DATA_LEN];
    end
endmodule

// File: rtl/cpu_state_unit.sv
// cpu_state_unit: PC register, integer register file and decoder key-lookup mux of the RV32 core.
module cpu_state_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_WIDTH = REG_ADDR_W,
    parameter int DATA_WIDTH = XLEN,
    parameter logic [DATA_WIDTH-1:0] PC_RESET = PC_RESET_VAL,
    parameter int NR_KEY = 1,
    parameter int KEY_LEN = 7,
    parameter int DATA_LEN = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 pc_wen,
    input  logic [DATA_WIDTH-1:0]                pc_din,
    output logic [DATA_WIDTH-1:0]                pc,
    output logic [DATA_WIDTH-1:0]                pc_plus4,
    input  logic                                 wen,
    input  logic [ADDR_WIDTH-1:0]                waddr,
    input  logic [DATA_WIDTH-1:0]                wdata,
    input  logic [ADDR_WIDTH-1:0]                rs1addr,
    input  logic [ADDR_WIDTH-1:0]                rs2addr,
    output logic [DATA_WIDTH-1:0]                rs1data,
    output logic [DATA_WIDTH-1:0]                rs2data,
    input  logic [KEY_LEN-1:0]                   key,
    input  logic [DATA_LEN-1:0]                  default_out,
    input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut,
    output logic [DATA_LEN-1:0]                  mux_out
);
    localparam int NR_REGS = 2 ** ADDR_WIDTH;
    localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

    gen_reg #(.WIDTH(DATA_WIDTH), .RESET_VAL(PC_RESET)) u_pc (
        .clk  (clk),
        .rst_n(rst),
        .en_i (pc_wen),
        .d_i  (pc_din),
        .q_o  (pc)
    );

    assign pc_plus4 = pc + PC_STEP;

    logic [DATA_WIDTH-1:0] regs_q [NR_REGS];

    // x0 is never written, and reads of it are forced to zero regardless.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) for (int i = 0; i < NR_REGS; i++) regs_q[i] <= '0;
        else if (wen && waddr != '0) regs_q[waddr] <= wdata;
    end

    assign rs1data = (rs1addr == '0) ? '0 : regs_q[rs1addr];
    assign rs2data = (rs2addr == '0) ? '0 : regs_q[rs2addr];

    key_mux #(.NR_KEY(NR_KEY), .KEY_LEN(KEY_LEN), .DATA_LEN(DATA_LEN)) u_key_mux (
        .key_i    (key),
        .default_i(default_out),
        .lut_i    (lut),
        .out_o    (mux_out)
    );
endmodule

// File: tb/tb_cpu_state_unit.sv
// tb_cpu_state_unit: directed plan checks plus randomized cycles against a behavioural model.
module tb_cpu_state_unit;
    import cpu_pkg::*;

    logic        clk = 0;
    logic        rst;
    logic        pc_wen;
    logic [31:0] pc_din;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  rs1addr;
    logic [4:0]  rs2addr;
    logic [31:0] rs1data;
    logic [31:0] rs2data;
    logic [6:0]  key;
    logic        default_out;
    logic [15:0] lut;
    logic        mux_out;
    logic [7:0]  lut1;
    logic [31:0] pc_b, pc_plus4_b, rs1data_b, rs2data_b;
    logic        mux_out_b;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_pc;

    always #5 clk = ~clk;

    cpu_state_unit #(.NR_KEY(2)) u_dut (
        .clk(clk), .rst(rst), .pc_wen(pc_wen), .pc_din(pc_din), .pc(pc), .pc_plus4(pc_plus4),
        .wen(wen), .waddr(waddr), .wdata(wdata), .rs1addr(rs1addr), .rs2addr(rs2addr),
        .rs1data(rs1data), .rs2data(rs2data), .key(key), .default_out(default_out),
        .lut(lut), .mux_out(mux_out)
    );

    cpu_state_unit u_dut1 (
        .clk(clk), .rst(rst), .pc_wen(pc_wen), .pc_din(pc_din), .pc(pc_b), .pc_plus4(pc_plus4_b),
        .wen(wen), .waddr(waddr), .wdata(wdata), .rs1addr(rs1addr), .rs2addr(rs2addr),
        .rs1data(rs1data_b), .rs2data(rs2data_b), .key(key), .default_out(default_out),
        .lut(lut1), .mux_out(mux_out_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = PC_RESET_VAL;
        foreach (m_regs[i]) m_regs[i] = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        return a == 0 ? 32'd0 : m_regs[a];
    endfunction

    // First entry (lowest index) whose key matches supplies the answer.
    function automatic logic m_mux(input logic [6:0] k, input logic d, input logic [15:0] t, input int n);
        for (int i = 0; i < n; i++) begin
            logic [7:0] e;
            e = t[i*8 +: 8];
            if (e[7:1] == k) return e[0];
        end
        return d;
    endfunction

    task automatic step();
        @(posedge clk);
        if (!rst) model_reset();
        else begin
            if (wen && waddr != 0) m_regs[waddr] = wdata;
            if (pc_wen) m_pc = pc_din;
        end
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        check({tag, ".pc"}, pc, m_pc);
        check({tag, ".pc4"}, pc_plus4, m_pc + 32'd4);
        check({tag, ".rs1"}, rs1data, m_read(rs1addr));
        check({tag, ".rs2"}, rs2data, m_read(rs2addr));
        check({tag, ".mux"}, 32'(mux_out), 32'(m_mux(key, default_out, lut, 2)));
        check({tag, ".mux1"}, 32'(mux_out_b), 32'(m_mux(key, default_out, {8'h0, lut1}, 1)));
        check({tag, ".rs1b"}, rs1data_b, m_read(rs1addr));
    endtask

    initial begin
        rst = 0; pc_wen = 0; pc_din = 0; wen = 0; waddr = 0; wdata = 0;
        rs1addr = 5; rs2addr = 31; key = 0; default_out = 0; lut = 0; lut1 = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1;
        #1;
        check("rst_pc", pc, 32'h8000_0000);
        check("rst_pc4", pc_plus4, 32'h8000_0004);
        check("rst_rs1", rs1data, 0);
        check("rst_rs2", rs2data, 0);

        wen = 1; waddr = 5; wdata = 32'hDEAD_BEEF; rs1addr = 5; rs2addr = 5;
        #1 check("rdw_old", rs1data, 0);
        step();
        wen = 0;
        #1;
        check("wr_rs1", rs1data, 32'hDEAD_BEEF);
        check("wr_rs2", rs2data, 32'hDEAD_BEEF);

        wen = 1; waddr = 0; wdata = 32'hFFFF_FFFF;
        step();
        rs1addr = 0; wen = 0; waddr = 7; wdata = 32'h1111_1111;
        step();
        rs2addr = 7;
        #1;
        check("x0_rd", rs1data, 0);
        check("nowen", rs2data, 0);

        pc_wen = 1; pc_din = 32'h8000_0010;
        step();
        #1 check("pc_upd", pc, 32'h8000_0010);
        pc_wen = 0; pc_din = 32'h1234_5678;
        step();
        #1 check("pc_hold", pc, 32'h8000_0010);
        pc_wen = 1; pc_din = 32'hFFFF_FFFC;
        step();
        pc_wen = 0;
        #1;
        check("pc_max", pc, 32'hFFFF_FFFC);
        check("pc4_wrap", pc_plus4, 0);

        lut = {OP_STORE, 1'b1, OP_LOAD, 1'b0}; default_out = 1;
        key = OP_LOAD;   #1 check("mux_load", 32'(mux_out), 0);
        key = OP_STORE;  #1 check("mux_store", 32'(mux_out), 1);
        key = OP_SYSTEM; #1 check("mux_def1", 32'(mux_out), 1);
        default_out = 0; #1 check("mux_def0", 32'(mux_out), 0);
        lut = {OP_SYSTEM, 1'b0, OP_SYSTEM, 1'b1}; #1 check("mux_dup", 32'(mux_out), 1);
        lut1 = {OP_SYSTEM, 1'b1}; #1 check("mux1_hit", 32'(mux_out_b), 1);
        key = OP_LOAD; #1 check("mux1_def", 32'(mux_out_b), 0);

        wen = 1; waddr = 3; wdata = 32'h1234;
        step();
        wen = 0; rs1addr = 3;
        #1 check("r3_set", rs1data, 32'h1234);
        #2 rst = 0;
        #1;
        check("arst_r3", rs1data, 0);
        check("arst_pc", pc, 32'h8000_0000);
        model_reset();
        wen = 1; waddr = 3; wdata = 32'h5555;
        step();
        rst = 1; wen = 0;
        #1 check("arst_nowr", rs1data, 0);

        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 39) != 0);
            if (!rst) model_reset();
            pc_wen = $urandom_range(0, 1);
            pc_din = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
            wen = ($urandom_range(0, 3) != 0);
            waddr = 5'($urandom);
            wdata = $urandom;
            rs1addr = 5'($urandom);
            rs2addr = ($urandom_range(0, 3) == 0) ? rs1addr : 5'($urandom);
            lut = 16'($urandom);
            if ($urandom_range(0, 3) == 0) lut[15:9] = lut[7:1];
            lut1 = 8'($urandom);
            key = $urandom_range(0, 1) ? lut[15:9] : ($urandom_range(0, 1) ? lut[7:1] : 7'($urandom));
            default_out = $urandom_range(0, 1);
            #1 check_model("rnd");
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
